sat_round_fp_pipe: RTL and testbench
====================================

Name: sat_round_fp_pipe

Overview:
Pipelined, multi-channel fixed-point requantizer. Converts N_CH signed Qm.n samples per beat to an output format with selectable truncate or round-half-up rounding, and saturates on overflow. Reports saturation per channel and can keep a running saturation-event count. Sits at datapath stage boundaries (after MAC/filter accumulators, before narrower buses) and carries valid/ready flow control.

Parameters:
NB_XI, 32, input word width per channel (signed)
NBF_XI, 30, input fractional bits
NB_XO, 16, output word width per channel (signed)
NBF_XO, 15, output fractional bits
N_CH, 2, number of parallel channels packed in i_data/o_data (channel k at bits [k*NB+:NB])
NB_CNT, 16, saturation event counter width

Ports:
i_clock  in  1  clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  input beat valid
i_data  in  N_CH*NB_XI  packed input samples
i_round  in  1  0 = truncate (floor), 1 = round-half-up; sampled with the beat
i_ready  in  1  downstream ready
o_ready  out  1  upstream ready (= i_ready, combinational)
o_valid  out  1  output beat valid
o_data  out  N_CH*NB_XO  packed requantized samples
o_sat  out  N_CH  per-channel saturation flag, aligned with o_data
o_sat_count  out  NB_CNT  beats with any channel saturated
i_clr_cnt  in  1  synchronous clear of o_sat_count

Behaviour:
- Reset (i_rst_n=0 at edge): o_valid=0, o_data=0, o_sat=0, o_sat_count=0, all stage valids=0. Reset mid-stream discards in-flight beats.
- Pipeline advances only when i_ready=1; when i_ready=0 all stage registers, o_valid, o_data, o_sat hold. Beat accepted when i_valid & o_ready.
- Latency: 2 advancing cycles from acceptance to o_valid. Throughput: 1 beat/cycle.
- Stage 1: per channel, sign-extend input to NB_XI+1 bits. If i_round=1 and NBF_XI>NBF_XO, add 2^(NBF_XI-NBF_XO-1); otherwise add 0. Register the result and stage-1 valid.
- Stage 2: fractional alignment. If NBF_XI>=NBF_XO, take NBF_XO bits below the binary point. Otherwise zero-pad on the right.
- Stage 2: integer range. Let NBI_XI=NB_XI-NBF_XI and NBI_XO=NB_XO-NBF_XO. If the (NBI_XI+1) integer bits exceed NBI_XO, the value is in range only when the top bits down to the output sign position all equal the sign. Out of range gives 0x7F..F (positive) or 0x80..0 (negative) and o_sat[k]=1. If NBI_XO is larger, sign-extend and never saturate. Register to o_data/o_sat/o_valid.
- Rounding carry that overflows the output range saturates; it never wraps.
- o_sat is qualified by o_valid. o_sat=0 whenever o_valid=0.
- Counter: increments on each advancing cycle where o_valid becomes 1 with any o_sat bit set. It holds at 2^NB_CNT-1 and does not wrap.
- Counter clear: i_clr_cnt=1 alone sets 0. Clear and an event in the same cycle set 1.

Optional Feature:
SAT_ROUND_FP_SAT_COUNTER_EN:
- Defined: o_sat_count and i_clr_cnt behave as specified.
- Undefined: no counter register is built, o_sat_count is tied to 0 and i_clr_cnt is ignored; all other behaviour is identical.

Test Plan:
- Default params, i_ready=1, i_round=0, ch0=0x20000000 and ch1=0xE0000000 -> 2 cycles later o_valid=1, o_data ch0=0x4000, ch1=0xC000, o_sat=00.
- Input 0x7FFFFFFF / 0x80000000 -> 0x7FFF / 0x8000 with o_sat=11. Counter: 1 with SAT_ROUND_FP_SAT_COUNTER_EN, 0 without.
- Rounding, 0x00004000 and 0xFFFFC000: i_round=0 -> 0x0000 / 0xFFFF; i_round=1 -> 0x0001 / 0x0000; o_sat=00.
- Rounding overflow, 0x3FFFFFFF: i_round=0 -> 0x7FFF with sat=0; i_round=1 -> 0x7FFF with sat=1.
- Back-to-back 4 beats, deassert i_ready for 3 cycles after beat 2 -> o_data/o_valid frozen, o_ready=0. Resume gives beats 3,4 in order with none lost or duplicated.
- NB_CNT=4: 20 saturating beats -> o_sat_count=15. Then i_clr_cnt with a saturating beat -> 1. Assert i_rst_n=0 mid-stream -> o_valid=0 and count=0 next edge.

Source files
------------

// File: rtl/sat_round_fp_pipe_if.sv
// Stream bus for sat_round_fp_pipe: valid/ready handshake, packed samples,
// rounding mode, per-channel saturation flags and saturation counter access.
interface sat_round_fp_pipe_if #(
  parameter int N_CH   = 2,
  parameter int NB_XI  = 32,
  parameter int NB_XO  = 16,
  parameter int NB_CNT = 16
) ();
  logic                    i_valid;
  logic [N_CH*NB_XI-1:0]   i_data;
  logic                    i_round;
  logic                    i_ready;
  logic                    i_clr_cnt;
  logic                    o_ready;
  logic                    o_valid;
  logic [N_CH*NB_XO-1:0]   o_data;
  logic [N_CH-1:0]         o_sat;
  logic [NB_CNT-1:0]       o_sat_count;

  modport slave (
    input  i_valid, i_data, i_round, i_ready, i_clr_cnt,
    output o_ready, o_valid, o_data, o_sat, o_sat_count
  );

  modport master (
    output i_valid, i_data, i_round, i_ready, i_clr_cnt,
    input  o_ready, o_valid, o_data, o_sat, o_sat_count
  );
endinterface

// File: rtl/sat_round_fp_pipe.sv
// Two-stage multi-channel Qm.n requantizer with truncate/round-half-up and saturation.
// Define SAT_ROUND_FP_SAT_COUNTER_EN to build the saturation event counter.

module sat_round_fp_lane #(
  parameter int NB_XI  = 32,
  parameter int NBF_XI = 30,
  parameter int NB_XO  = 16,
  parameter int NBF_XO = 15
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_adv,
  input  logic             i_v1,
  input  logic             i_round,
  input  logic [NB_XI-1:0] i_x,
  output logic [NB_XO-1:0] o_y,
  output logic             o_sat,
  output logic             o_sat_nxt
);
  localparam int W      = NB_XI + 1;
  localparam int NBI_XI = NB_XI - NBF_XI;
  localparam int WA     = NBI_XI + 1 + NBF_XO;

  logic [W-1:0]     s1_q, s1_d, rnd_add;
  logic [WA-1:0]    a;
  logic [NB_XO-1:0] y_c, y_q, y_d;
  logic             sat_c, sat_q, sat_d;

  if (NBF_XI > NBF_XO) begin : g_rnd
    assign rnd_add = i_round ? ({{(W-1){1'b0}}, 1'b1} << (NBF_XI - NBF_XO - 1)) : '0;
    // Bits below the output LSB only feed the rounding carry.
    logic unused_lsb;
    assign unused_lsb = ^s1_q[NBF_XI-NBF_XO-1:0];
  end else begin : g_nornd
    assign rnd_add = '0;
    logic unused_round;
    assign unused_round = i_round;
  end

  if (NBF_XI >= NBF_XO) begin : g_shr
    assign a = s1_q[W-1 -: WA];
  end else begin : g_shl
    assign a = {s1_q, {(NBF_XO-NBF_XI){1'b0}}};
  end

  if (WA > NB_XO) begin : g_sat
    logic in_rng;
    assign in_rng = (a[WA-1:NB_XO-1] == {(WA-NB_XO+1){a[WA-1]}});
    assign y_c    = in_rng ? a[NB_XO-1:0] : {a[WA-1], {(NB_XO-1){~a[WA-1]}}};
    assign sat_c  = ~in_rng;
  end else begin : g_ext
    assign y_c   = NB_XO'(signed'(a));
    assign sat_c = 1'b0;
  end

  assign o_sat_nxt = sat_c & i_v1;

  always_comb begin
    s1_d  = s1_q;
    y_d   = y_q;
    sat_d = sat_q;
    if (i_adv) begin
      s1_d  = {i_x[NB_XI-1], i_x} + rnd_add;
      y_d   = y_c;
      sat_d = o_sat_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      s1_q  <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign o_y   = y_q;
  assign o_sat = sat_q;
endmodule

module sat_round_fp_pipe #(
  parameter int NB_XI  = 32,
  parameter int NBF_XI = 30,
  parameter int NB_XO  = 16,
  parameter int NBF_XO = 15,
  parameter int N_CH   = 2,
  parameter int NB_CNT = 16
) (
  input logic               i_clock,
  input logic               i_rst_n,
  sat_round_fp_pipe_if.slave bus
);
  logic                        adv;
  logic [1:0]                  vld_pipe_q, vld_pipe_d;
  logic [N_CH-1:0][NB_XO-1:0]  y;
  logic [N_CH-1:0]             sat_q, sat_nxt;

  // The whole pipe stalls on downstream backpressure, so upstream ready is a wire.
  assign adv         = bus.i_ready;
  assign bus.o_ready = bus.i_ready;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) vld_pipe_d = {vld_pipe_q[0], bus.i_valid};
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) vld_pipe_q <= '0;
    else          vld_pipe_q <= vld_pipe_d;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    sat_round_fp_lane #(
      .NB_XI(NB_XI), .NBF_XI(NBF_XI), .NB_XO(NB_XO), .NBF_XO(NBF_XO)
    ) u_lane (
      .i_clock   (i_clock),
      .i_rst_n   (i_rst_n),
      .i_adv     (adv),
      .i_v1      (vld_pipe_q[0]),
      .i_round   (bus.i_round),
      .i_x       (bus.i_data[k*NB_XI +: NB_XI]),
      .o_y       (y[k]),
      .o_sat     (sat_q[k]),
      .o_sat_nxt (sat_nxt[k])
    );
  end

  assign bus.o_valid = vld_pipe_q[1];
  assign bus.o_data  = y;
  assign bus.o_sat   = sat_q & {N_CH{vld_pipe_q[1]}};

`ifdef SAT_ROUND_FP_SAT_COUNTER_EN
  logic              sat_evt;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  assign sat_evt = adv & vld_pipe_q[0] & (|sat_nxt);

  // Clear wins over the old count, but a same-cycle event still lands as 1.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_clr_cnt)                  cnt_d = sat_evt ? NB_CNT'(1) : '0;
    else if (sat_evt && (cnt_q != '1))  cnt_d = cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.o_sat_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt      = bus.i_clr_cnt ^ (^sat_nxt);
  assign bus.o_sat_count = '0;
`endif
endmodule

// File: tb/tb_sat_round_fp_pipe.sv
// Scoreboard bench for sat_round_fp_pipe (Q2.30 -> Q1.15, 2 channels, 4-bit counter).
module tb_sat_round_fp_pipe;
  localparam int N_CH = 2, NB_XI = 32, NB_XO = 16, NB_CNT = 4;
`ifdef SAT_ROUND_FP_SAT_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sat;
  } beat_t;

  logic  i_clock = 1'b0;
  logic  i_rst_n = 1'b0;
  beat_t sb_q[$];
  beat_t mon_e;
  int    n_cmp = 0, n_err = 0, sat_cnt_exp = 0;

  always #5 i_clock = ~i_clock;

  sat_round_fp_pipe_if #(.N_CH(N_CH), .NB_XI(NB_XI), .NB_XO(NB_XO), .NB_CNT(NB_CNT)) bus ();

  sat_round_fp_pipe #(
    .NB_XI(32), .NBF_XI(30), .NB_XO(16), .NBF_XO(15), .N_CH(N_CH), .NB_CNT(NB_CNT)
  ) dut (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference: scale by 2^-15 with floor, optional +0.5 LSB, clamp to int16.
  function automatic logic [16:0] req1(input logic [31:0] x, input logic rnd);
    longint v;
    v = longint'($signed(x));
    if (rnd) v = v + 64'sd16384;
    v = v >>> 15;
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic beat_t model(input logic [31:0] c0, input logic [31:0] c1, input logic rnd);
    logic [16:0] r0, r1;
    beat_t e;
    r0 = req1(c0, rnd);
    r1 = req1(c1, rnd);
    e.data = {r1[15:0], r0[15:0]};
    e.sat  = {r1[16], r0[16]};
    return e;
  endfunction

  task automatic send(input logic [31:0] c0, input logic [31:0] c1, input logic rnd);
    bit    acc;
    beat_t e;
    acc = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = {c1, c0};
    bus.i_round = rnd;
    for (int n = 0; n < 50; n++) begin
      @(posedge i_clock);
      if (bus.o_ready) begin acc = 1'b1; break; end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else begin
      e = model(c0, c1, rnd);
      sb_q.push_back(e);
      if ((|e.sat) && sat_cnt_exp < 15) sat_cnt_exp++;
    end
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge i_clock);
    #1 chk("drain_empty", 64'(sb_q.size()), 0);
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 64'(bus.o_sat_count), CNT_EN ? 64'(sat_cnt_exp) : 64'd0);
  endtask

  always @(negedge i_clock) begin
    if (i_rst_n) begin
      if (!bus.o_valid) chk("sat_idle", 64'(bus.o_sat), 0);
      if (bus.o_valid && bus.i_ready) begin
        if (sb_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("data", 64'(bus.o_data), 64'(mon_e.data));
          chk("sat", 64'(bus.o_sat), 64'(mon_e.sat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t       e1;
    logic [31:0] r0, r1;
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    bus.i_round   = 1'b0;
    bus.i_ready   = 1'b1;
    bus.i_clr_cnt = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_valid", 64'(bus.o_valid), 0);
    chk("rst_data", 64'(bus.o_data), 0);
    chk("rst_sat", 64'(bus.o_sat), 0);
    chk("rst_cnt", 64'(bus.o_sat_count), 0);
    i_rst_n = 1'b1;

    // Directed: scaling, full-scale saturation, rounding and rounding overflow.
    send(32'h2000_0000, 32'hE000_0000, 1'b0);
    send(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    send(32'h0000_4000, 32'hFFFF_C000, 1'b0);
    send(32'h0000_4000, 32'hFFFF_C000, 1'b1);
    send(32'h3FFF_FFFF, 32'hC000_0000, 1'b0);
    send(32'h3FFF_FFFF, 32'hC000_0000, 1'b1);
    send(32'h3FFF_C000, 32'h3FFF_BFFF, 1'b1);
    drain();
    chk_cnt("cnt_directed");

    for (int i = 0; i < 24; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      if (i % 2 == 1) begin
        r0 = {{3{r0[28]}}, r0[28:0]};
        r1 = {{3{r1[28]}}, r1[28:0]};
      end
      send(r0, r1, 1'($urandom_range(0, 1)));
    end
    drain();
    chk_cnt("cnt_random");

    // Backpressure: beat 1 sits at the output while beat 3 waits upstream.
    e1 = model(32'h1000_0000, 32'hF000_0000, 1'b0);
    send(32'h1000_0000, 32'hF000_0000, 1'b0);
    send(32'h0800_0000, 32'h7000_0000, 1'b1);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = {32'h0400_0000, 32'hC800_0000};
    bus.i_round = 1'b0;
    repeat (3) begin
      @(negedge i_clock);
      chk("stall_valid", 64'(bus.o_valid), 1);
      chk("stall_ready", 64'(bus.o_ready), 0);
      chk("stall_data", 64'(bus.o_data), 64'(e1.data));
    end
    @(posedge i_clock);
    #1 bus.i_ready = 1'b1;
    send(32'hC800_0000, 32'h0400_0000, 1'b0);
    send(32'h0123_4567, 32'hFEDC_BA98, 1'b1);
    drain();

    bus.i_clr_cnt = 1'b1;
    @(posedge i_clock);
    #1 bus.i_clr_cnt = 1'b0;
    sat_cnt_exp = 0;
    chk_cnt("cnt_clear");

    for (int i = 0; i < 20; i++) send(32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
    drain();
    chk_cnt("cnt_hold");

    // Clear lands on the same edge the saturating beat reaches the output.
    send(32'h0000_0000, 32'h8000_0000, 1'b0);
    bus.i_clr_cnt = 1'b1;
    @(posedge i_clock);
    #1 bus.i_clr_cnt = 1'b0;
    sat_cnt_exp = 1;
    chk_cnt("cnt_clr_evt");
    drain();

    send(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    send(32'h1000_0000, 32'h1000_0000, 1'b0);
    i_rst_n = 1'b0;
    @(posedge i_clock);
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 0);
    chk("midrst_cnt", 64'(bus.o_sat_count), 0);
    chk("midrst_sat", 64'(bus.o_sat), 0);
    sb_q.delete();
    sat_cnt_exp = 0;
    i_rst_n = 1'b1;
    send(32'h2000_0000, 32'hE000_0000, 1'b1);
    drain();
    chk_cnt("cnt_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
